// File: rtl/i2cmb_rtl_pkg.sv
// Shared types for the I2CMB byte-level command engine.
package i2cmb_rtl_pkg;

    localparam int unsigned BUS_ID_W = 4;
    localparam int unsigned DATA_W   = 8;

    typedef enum logic [2:0] {
        CMD_WAIT     = 3'd0,
        CMD_WRITE    = 3'd1,
        CMD_READ_ACK = 3'd2,
        CMD_READ_NAK = 3'd3,
        CMD_START    = 3'd4,
        CMD_STOP     = 3'd5,
        CMD_SET_BUS  = 3'd6,
        CMD_RSVD     = 3'd7
    } cmd_code_t;

    typedef enum logic [1:0] {
        RSP_DONE     = 2'd0,
        RSP_ARB_LOST = 2'd1,
        RSP_NAK      = 2'd2,
        RSP_ERR      = 2'd3
    } rsp_code_t;

    typedef enum logic [1:0] {
        BIT_START = 2'd0,
        BIT_STOP  = 2'd1,
        BIT_WRITE = 2'd2,
        BIT_READ  = 2'd3
    } bit_cmd_t;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START  = 4'd1,
        ST_STOP   = 4'd2,
        ST_WR_BIT = 4'd3,
        ST_WR_ACK = 4'd4,
        ST_RD_BIT = 4'd5,
        ST_RD_ACK = 4'd6,
        ST_WAIT   = 4'd7,
        ST_RESP   = 4'd8
    } byte_state_t;

endpackage

// File: rtl/i2cmb_byte_ctrl_if.sv
// Command/response and bit-sequencer handshake bundle of the byte engine.
interface i2cmb_byte_ctrl_if;

    logic                                   cmd_valid_i;
    logic                                   cmd_ready_o;
    logic [2:0]                             cmd_code_i;
    logic [i2cmb_rtl_pkg::DATA_W-1:0]       cmd_data_i;
    logic                                   rsp_valid_o;
    logic [1:0]                             rsp_code_o;
    logic [i2cmb_rtl_pkg::DATA_W-1:0]       rsp_data_o;
    logic [i2cmb_rtl_pkg::BUS_ID_W-1:0]     bus_sel_o;
    logic                                   bus_captured_o;
    logic                                   bit_cmd_valid_o;
    logic [1:0]                             bit_cmd_o;
    logic                                   bit_wdat_o;
    logic                                   bit_done_i;
    logic                                   bit_arb_lost_i;
    logic                                   bit_rdat_i;

    // Engine side
    modport master (
        input  cmd_valid_i, cmd_code_i, cmd_data_i, bit_done_i, bit_arb_lost_i, bit_rdat_i,
        output cmd_ready_o, rsp_valid_o, rsp_code_o, rsp_data_o, bus_sel_o, bus_captured_o,
               bit_cmd_valid_o, bit_cmd_o, bit_wdat_o
    );

    // Register block / bit sequencer side
    modport slave (
        output cmd_valid_i, cmd_code_i, cmd_data_i, bit_done_i, bit_arb_lost_i, bit_rdat_i,
        input  cmd_ready_o, rsp_valid_o, rsp_code_o, rsp_data_o, bus_sel_o, bus_captured_o,
               bit_cmd_valid_o, bit_cmd_o, bit_wdat_o
    );

endinterface

// File: rtl/i2cmb_ms_timer.sv
// Millisecond countdown for WAIT; done_c is high in the last cycle of the wait.
module i2cmb_ms_timer #(
    parameter int unsigned CLK_PER_MS = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] ms,
    output logic       done_c
);

    localparam int unsigned CYC_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    logic             running_q;
    logic [7:0]       ms_q;
    logic [CYC_W-1:0] cyc_q;

    assign done_c = running_q && (ms_q == 8'd1) && (cyc_q == '0);

    // First period is one shorter because the acceptance cycle already counts (CLK_PER_MS >= 2).
    always_ff @(posedge clk) begin
        if (rst) begin
            running_q <= 1'b0;
            ms_q      <= '0;
            cyc_q     <= '0;
        end else if (load) begin
            running_q <= 1'b1;
            ms_q      <= ms;
            cyc_q     <= CYC_W'(CLK_PER_MS - 2);
        end else if (running_q) begin
            if (cyc_q == '0) begin
                if (done_c) begin
                    running_q <= 1'b0;
                end else begin
                    ms_q  <= ms_q - 8'd1;
                    cyc_q <= CYC_W'(CLK_PER_MS - 1);
                end
            end else begin
                cyc_q <= cyc_q - CYC_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2cmb_byte_ctrl.sv
// Byte-level I2C command engine: expands one byte command into bit commands and returns a response.
module i2cmb_byte_ctrl
    import i2cmb_rtl_pkg::*;
#(
    parameter int unsigned NUM_BUSES  = 16,
    parameter int unsigned CLK_PER_MS = 100000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    i2cmb_byte_ctrl_if.master  bus
);

    byte_state_t            state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    cmd_code_t              code_q, code_d;
    logic                   bit_valid_q, bit_valid_d;
    bit_cmd_t               bit_cmd_q, bit_cmd_d;
    logic                   bit_wdat_q, bit_wdat_d;
    logic                   rsp_valid_q, rsp_valid_d;
    rsp_code_t              rsp_code_q, rsp_code_d;
    logic [DATA_W-1:0]      rsp_data_q, rsp_data_d;
    logic [BUS_ID_W-1:0]    bus_sel_q, bus_sel_d;
    logic                   captured_q, captured_d;
    logic                   ready_q, ready_d;
    rsp_code_t              imm_code;
    logic                   timer_load;
    logic                   timer_done_c;
    cmd_code_t              code_in;

    assign code_in = cmd_code_t'(bus.cmd_code_i);

    i2cmb_ms_timer #(.CLK_PER_MS(CLK_PER_MS)) u_timer (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (timer_load),
        .ms     (bus.cmd_data_i),
        .done_c (timer_done_c)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            code_q      <= CMD_WAIT;
            bit_valid_q <= 1'b0;
            bit_cmd_q   <= BIT_START;
            bit_wdat_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= RSP_DONE;
            rsp_data_q  <= '0;
            bus_sel_q   <= '0;
            captured_q  <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            code_q      <= code_d;
            bit_valid_q <= bit_valid_d;
            bit_cmd_q   <= bit_cmd_d;
            bit_wdat_q  <= bit_wdat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_code_q  <= rsp_code_d;
            rsp_data_q  <= rsp_data_d;
            bus_sel_q   <= bus_sel_d;
            captured_q  <= captured_d;
            ready_q     <= ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        code_d      = code_q;
        bit_valid_d = bit_valid_q;
        bit_cmd_d   = bit_cmd_q;
        bit_wdat_d  = bit_wdat_q;
        rsp_code_d  = rsp_code_q;
        rsp_data_d  = rsp_data_q;
        bus_sel_d   = bus_sel_q;
        captured_d  = captured_q;
        imm_code    = RSP_ERR;
        timer_load  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid_i && ready_q) begin
                    code_d  = code_in;
                    shift_d = bus.cmd_data_i;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                    case (code_in)
                        CMD_WAIT: if (!captured_q) begin
                            if (bus.cmd_data_i == '0) imm_code = RSP_DONE;
                            else begin
                                timer_load = 1'b1;
                                state_d    = ST_WAIT;
                            end
                        end
                        CMD_WRITE:    if (captured_q) state_d = ST_WR_BIT;
                        CMD_READ_ACK,
                        CMD_READ_NAK: if (captured_q) state_d = ST_RD_BIT;
                        CMD_START:    state_d = ST_START;
                        CMD_STOP:     if (captured_q) state_d = ST_STOP;
                        CMD_SET_BUS:  if (!captured_q && ({1'b0, bus.cmd_data_i} < 9'(NUM_BUSES))) begin
                            bus_sel_d = bus.cmd_data_i[BUS_ID_W-1:0];
                            imm_code  = RSP_DONE;
                        end
                        default: ;
                    endcase
                    if (state_d == ST_RESP) rsp_code_d = imm_code;
                end
            end

            // Shared bit handshake: raise, hold until done/arb, then drop for one cycle.
            ST_START, ST_STOP, ST_WR_BIT, ST_WR_ACK, ST_RD_BIT, ST_RD_ACK: begin
                if (!bit_valid_q) begin
                    bit_valid_d = 1'b1;
                    bit_wdat_d  = 1'b0;
                    case (state_q)
                        ST_START:  bit_cmd_d = BIT_START;
                        ST_STOP:   bit_cmd_d = BIT_STOP;
                        ST_WR_BIT: begin
                            bit_cmd_d  = BIT_WRITE;
                            bit_wdat_d = shift_q[DATA_W-1];
                        end
                        ST_RD_ACK: begin
                            bit_cmd_d  = BIT_WRITE;
                            bit_wdat_d = (code_q == CMD_READ_NAK);
                        end
                        default:   bit_cmd_d = BIT_READ;
                    endcase
                end else if (bus.bit_arb_lost_i) begin
                    bit_valid_d = 1'b0;
                    captured_d  = 1'b0;
                    rsp_code_d  = RSP_ARB_LOST;
                    state_d     = ST_RESP;
                end else if (bus.bit_done_i) begin
                    bit_valid_d = 1'b0;
                    case (state_q)
                        ST_START: begin
                            captured_d = 1'b1;
                            rsp_code_d = RSP_DONE;
                            state_d    = ST_RESP;
                        end
                        ST_STOP: begin
                            captured_d = 1'b0;
                            rsp_code_d = RSP_DONE;
                            state_d    = ST_RESP;
                        end
                        ST_WR_BIT: begin
                            shift_d = {shift_q[DATA_W-2:0], 1'b0};
                            cnt_d   = cnt_q + 3'd1;
                            if (cnt_q == 3'd7) state_d = ST_WR_ACK;
                        end
                        ST_WR_ACK: begin
                            rsp_code_d = bus.bit_rdat_i ? RSP_NAK : RSP_DONE;
                            state_d    = ST_RESP;
                        end
                        ST_RD_BIT: begin
                            shift_d = {shift_q[DATA_W-2:0], bus.bit_rdat_i};
                            cnt_d   = cnt_q + 3'd1;
                            if (cnt_q == 3'd7) state_d = ST_RD_ACK;
                        end
                        default: begin
                            rsp_data_d = shift_q;
                            rsp_code_d = RSP_DONE;
                            state_d    = ST_RESP;
                        end
                    endcase
                end
            end

            ST_WAIT: begin
                if (timer_done_c) begin
                    rsp_code_d = RSP_DONE;
                    state_d    = ST_RESP;
                end
            end

            ST_RESP: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase

        rsp_valid_d = (state_d == ST_RESP);
        ready_d     = (state_d == ST_IDLE);
    end

    assign bus.cmd_ready_o     = ready_q;
    assign bus.rsp_valid_o     = rsp_valid_q;
    assign bus.rsp_code_o      = rsp_code_q;
    assign bus.rsp_data_o      = rsp_data_q;
    assign bus.bus_sel_o       = bus_sel_q;
    assign bus.bus_captured_o  = captured_q;
    assign bus.bit_cmd_valid_o = bit_valid_q;
    assign bus.bit_cmd_o       = bit_cmd_q;
    assign bus.bit_wdat_o      = bit_wdat_q;

endmodule

// File: tb/tb_i2cmb_byte_ctrl.sv
// Directed self-checking bench for i2cmb_byte_ctrl; the bench plays register block and bit sequencer.
module tb_i2cmb_byte_ctrl;

    localparam logic [2:0] C_WAIT = 3'd0, C_WRITE = 3'd1, C_RACK = 3'd2, C_RNAK = 3'd3;
    localparam logic [2:0] C_START = 3'd4, C_STOP = 3'd5, C_SETBUS = 3'd6, C_RSVD = 3'd7;
    localparam logic [1:0] B_START = 2'd0, B_STOP = 2'd1, B_WRITE = 2'd2, B_READ = 2'd3;
    localparam logic [1:0] R_DONE = 2'd0, R_ARB = 2'd1, R_NAK = 2'd2, R_ERR = 2'd3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    i2cmb_byte_ctrl_if bus();

    i2cmb_byte_ctrl #(.NUM_BUSES(16), .CLK_PER_MS(10)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [2:0] code, input logic [7:0] data);
        int n = 0;
        while (bus.cmd_ready_o !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_code_i  = code;
        bus.cmd_data_i  = data;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [1:0] code, input int max_wait);
        int n = 0;
        while (bus.rsp_valid_o !== 1'b1 && n < max_wait) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'd1);
        chk({tag, "_rsp_code"}, 32'(bus.rsp_code_o), 32'(code));
        @(negedge clk);
        chk({tag, "_rsp_pulse"}, 32'(bus.rsp_valid_o), 32'd0);
    endtask

    task automatic serve_bit(input string tag, input logic [1:0] cmd, input logic chk_wdat,
                             input logic wdat, input logic rdat, input logic arb);
        int n = 0;
        while (bus.bit_cmd_valid_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_bvalid"}, 32'(bus.bit_cmd_valid_o), 32'd1);
        chk({tag, "_bcmd"}, 32'(bus.bit_cmd_o), 32'(cmd));
        if (chk_wdat) chk({tag, "_wdat"}, 32'(bus.bit_wdat_o), 32'(wdat));
        @(negedge clk);
        chk({tag, "_hold"}, 32'({bus.bit_cmd_valid_o, bus.bit_cmd_o}), 32'({1'b1, cmd}));
        bus.bit_done_i     = ~arb;
        bus.bit_arb_lost_i = arb;
        bus.bit_rdat_i     = rdat;
        @(negedge clk);
        bus.bit_done_i     = 1'b0;
        bus.bit_arb_lost_i = 1'b0;
        bus.bit_rdat_i     = 1'b0;
        chk({tag, "_gap"}, 32'(bus.bit_cmd_valid_o), 32'd0);
    endtask

    initial begin
        logic [7:0] wb;
        logic [7:0] rb;
        int n;

        rst = 1'b1;
        bus.cmd_valid_i    = 1'b0;
        bus.cmd_code_i     = 3'd0;
        bus.cmd_data_i     = 8'd0;
        bus.bit_done_i     = 1'b0;
        bus.bit_arb_lost_i = 1'b0;
        bus.bit_rdat_i     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.cmd_ready_o), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst_bus_sel", 32'(bus.bus_sel_o), 32'd0);
        chk("rst_captured", 32'(bus.bus_captured_o), 32'd0);
        chk("rst_bvalid", 32'(bus.bit_cmd_valid_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.cmd_ready_o), 32'd1);

        // SET_BUS 3, START, WRITE 0xA5 acked
        send_cmd(C_SETBUS, 8'd3);
        expect_rsp("setbus3", R_DONE, 0);
        chk("setbus3_sel", 32'(bus.bus_sel_o), 32'd3);
        send_cmd(C_START, 8'd0);
        serve_bit("start1", B_START, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_rsp("start1", R_DONE, 0);
        chk("start1_cap", 32'(bus.bus_captured_o), 32'd1);
        wb = 8'hA5;
        send_cmd(C_WRITE, wb);
        for (int i = 0; i < 8; i++) serve_bit("wrA5", B_WRITE, 1'b1, wb[7-i], 1'b0, 1'b0);
        serve_bit("wrA5_ack", B_READ, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_rsp("wrA5", R_DONE, 0);
        chk("wrA5_sel", 32'(bus.bus_sel_o), 32'd3);
        chk("wrA5_cap", 32'(bus.bus_captured_o), 32'd1);

        // READ_NAK of 0x69, then STOP
        rb = 8'h69;
        send_cmd(C_RNAK, 8'd0);
        for (int i = 0; i < 8; i++) serve_bit("rdnak", B_READ, 1'b0, 1'b0, rb[7-i], 1'b0);
        serve_bit("rdnak_ack", B_WRITE, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_rsp("rdnak", R_DONE, 0);
        chk("rdnak_data", 32'(bus.rsp_data_o), 32'h69);
        send_cmd(C_STOP, 8'd0);
        serve_bit("stop1", B_STOP, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_rsp("stop1", R_DONE, 0);
        chk("stop1_cap", 32'(bus.bus_captured_o), 32'd0);

        // WRITE 0x00 NAKed keeps the bus
        send_cmd(C_START, 8'd0);
        serve_bit("start2", B_START, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_rsp("start2", R_DONE, 0);
        send_cmd(C_WRITE, 8'h00);
        for (int i = 0; i < 8; i++) serve_bit("wr00", B_WRITE, 1'b1, 1'b0, 1'b0, 1'b0);
        serve_bit("wr00_ack", B_READ, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_rsp("wr00", R_NAK, 0);
        chk("wr00_cap", 32'(bus.bus_captured_o), 32'd1);
        send_cmd(C_STOP, 8'd0);
        serve_bit("stop2", B_STOP, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_rsp("stop2", R_DONE, 0);

        // WRITE while not captured
        send_cmd(C_WRITE, 8'h5A);
        expect_rsp("wr_nocap", R_ERR, 0);
        for (int i = 0; i < 3; i++) begin
            chk("wr_nocap_nobit", 32'(bus.bit_cmd_valid_o), 32'd0);
            @(negedge clk);
        end

        // Arbitration lost on 3rd bit of WRITE 0xFF
        send_cmd(C_START, 8'd0);
        serve_bit("start3", B_START, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_rsp("start3", R_DONE, 0);
        send_cmd(C_WRITE, 8'hFF);
        serve_bit("arb_b1", B_WRITE, 1'b1, 1'b1, 1'b0, 1'b0);
        serve_bit("arb_b2", B_WRITE, 1'b1, 1'b1, 1'b0, 1'b0);
        serve_bit("arb_b3", B_WRITE, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_rsp("arb", R_ARB, 0);
        chk("arb_cap", 32'(bus.bus_captured_o), 32'd0);
        chk("arb_data", 32'(bus.rsp_data_o), 32'h69);
        for (int i = 0; i < 4; i++) begin
            chk("arb_nostop", 32'(bus.bit_cmd_valid_o), 32'd0);
            @(negedge clk);
        end

        // WAIT 2 ms at 10 clk/ms: pulse 20 cycles after acceptance
        send_cmd(C_WAIT, 8'd2);
        for (int k = 1; k < 20; k++) begin
            chk("wait2_early", 32'(bus.rsp_valid_o), 32'd0);
            @(negedge clk);
        end
        expect_rsp("wait2", R_DONE, 0);
        send_cmd(C_WAIT, 8'd0);
        expect_rsp("wait0", R_DONE, 0);

        // Bad bus id and reserved code
        send_cmd(C_SETBUS, 8'd16);
        expect_rsp("setbus16", R_ERR, 0);
        chk("setbus16_sel", 32'(bus.bus_sel_o), 32'd3);
        send_cmd(C_RSVD, 8'd0);
        expect_rsp("rsvd", R_ERR, 0);

        // Reset during the 5th READ bit
        send_cmd(C_START, 8'd0);
        serve_bit("start4", B_START, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_rsp("start4", R_DONE, 0);
        send_cmd(C_RACK, 8'd0);
        for (int i = 0; i < 4; i++) serve_bit("rdrst", B_READ, 1'b0, 1'b0, 1'b1, 1'b0);
        n = 0;
        while (bus.bit_cmd_valid_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rdrst_b5_valid", 32'(bus.bit_cmd_valid_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_bvalid", 32'(bus.bit_cmd_valid_o), 32'd0);
        chk("mid_rst_cap", 32'(bus.bus_captured_o), 32'd0);
        chk("mid_rst_sel", 32'(bus.bus_sel_o), 32'd0);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("mid_rst_ready", 32'(bus.cmd_ready_o), 32'd0);
        chk("mid_rst_rsp_data", 32'(bus.rsp_data_o), 32'd0);
        chk("mid_rst_rsp_code", 32'(bus.rsp_code_o), 32'd0);
        chk("mid_rst_bcmd", 32'({bus.bit_cmd_o, bus.bit_wdat_o}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready_back", 32'(bus.cmd_ready_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
            chk("mid_rst_no_bit", 32'(bus.bit_cmd_valid_o), 32'd0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
